// File: rtl/can_rx_msg_buffer_pkg.sv
// Shared types and register-map constants for the CAN receive message buffer.
package can_rx_pkg;

   typedef struct packed {
      logic [10:0] id;
      logic        rtr;
      logic [3:0]  dlc;
      logic [63:0] data;
   } frame_t;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_UPDATE = 1'b1
   } state_t;

   localparam int N_WORDS = 4;

   localparam int CTRL  = 0;
   localparam int IDDLC = 1;
   localparam int DLO   = 2;
   localparam int DHI   = 3;

   localparam int POP_BIT      = 0;
   localparam int OVF_CLR_BIT  = 1;
   localparam int VALID_BIT    = 8;
   localparam int OVF_BIT      = 9;
   localparam int COUNT_LSB    = 16;
   localparam int DROP_CNT_LSB = 24;

   function automatic logic [31:0] id_word(input frame_t f);
      return {12'b0, f.dlc, f.rtr, 4'b0, f.id};
   endfunction

endpackage

// File: rtl/can_rx_msg_buffer_if.sv
// Frame-decoder and register-interface signals seen by the RX message buffer.
interface can_rx_msg_buffer_if;
   logic              frm_valid_i;
   logic [10:0]       frm_id_i;
   logic              frm_rtr_i;
   logic [3:0]        frm_dlc_i;
   logic [63:0]       frm_data_i;
   logic [3:0][31:0]  reg_data_o;
   logic              new_data_o;
   logic [3:0][31:0]  reg_data_i;

   modport master (
      output frm_valid_i, frm_id_i, frm_rtr_i, frm_dlc_i, frm_data_i, reg_data_i,
      input  reg_data_o, new_data_o
   );

   modport slave (
      input  frm_valid_i, frm_id_i, frm_rtr_i, frm_dlc_i, frm_data_i, reg_data_i,
      output reg_data_o, new_data_o
   );
endinterface

// File: rtl/can_rx_msg_buffer_sync_fifo.sv
// Generic synchronous FIFO with first-word fall-through head and occupancy count.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push && rst_n) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/can_rx_msg_buffer.sv
// Queues received CAN frames and mirrors head frame plus status into a 4-word register image.
//   state     | meaning
//   ST_IDLE   | image current; software commands in CTRL are accepted
//   ST_UPDATE | new_data_o high; register interface loads the image this cycle
module can_rx_msg_buffer
   import can_rx_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   can_rx_msg_buffer_if.slave  bus
);
   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_dirty;
   logic             w_dirty_nxt;
   logic             r_ovf;
   logic [7:0]       r_drop_cnt;

   logic             w_cmd_pop;
   logic             w_cmd_clr;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic             w_event;
   frame_t           w_frm_in;
   frame_t           w_head;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W-1:0] w_count;
   logic [3:0][31:0] w_image;
   logic             w_unused_reg;

   assign w_frm_in = '{id: bus.frm_id_i, rtr: bus.frm_rtr_i, dlc: bus.frm_dlc_i, data: bus.frm_data_i};

   // Command bits linger in CTRL until the next image load, so they only count in IDLE.
   assign w_cmd_pop = (r_state == ST_IDLE) && bus.reg_data_i[CTRL][POP_BIT];
   assign w_cmd_clr = (r_state == ST_IDLE) && bus.reg_data_i[CTRL][OVF_CLR_BIT];
   assign w_pop     = w_cmd_pop && !w_empty;
   assign w_push    = bus.frm_valid_i && (!w_full || w_pop);
   assign w_drop    = bus.frm_valid_i && w_full && !w_pop;
   assign w_event   = bus.frm_valid_i || w_cmd_pop || w_cmd_clr;

   assign w_unused_reg = ^{bus.reg_data_i[CTRL][31:2], bus.reg_data_i[IDDLC],
                           bus.reg_data_i[DLO], bus.reg_data_i[DHI]};

   sync_fifo #(
      .WIDTH ($bits(frame_t)),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_frm_in),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_dirty_nxt = r_dirty || w_event;
      case (r_state)
         ST_IDLE: begin
            if (r_dirty || w_event) w_state_nxt = ST_UPDATE;
         end
         ST_UPDATE: begin
            if (!w_event) begin
               w_state_nxt = ST_IDLE;
               w_dirty_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_dirty_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_dirty    <= 1'b0;
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_dirty <= w_dirty_nxt;
         if (w_drop)         r_ovf <= 1'b1;
         else if (w_cmd_clr) r_ovf <= 1'b0;
         if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   always_comb begin
      w_image = '0;
      w_image[CTRL][VALID_BIT]                 = !w_empty;
      w_image[CTRL][OVF_BIT]                   = r_ovf;
      w_image[CTRL][COUNT_LSB +: 8]            = 8'(w_count);
      w_image[CTRL][DROP_CNT_LSB +: 8]         = r_drop_cnt;
      if (!w_empty) begin
         w_image[IDDLC] = id_word(w_head);
         w_image[DLO]   = w_head.data[31:0];
         w_image[DHI]   = w_head.data[63:32];
      end
   end

   assign bus.reg_data_o = w_image;
   assign bus.new_data_o = (r_state == ST_UPDATE);
endmodule

// File: tb/tb_can_rx_msg_buffer.sv
// Scoreboard bench for can_rx_msg_buffer with a behavioural model of the register interface.
module tb_can_rx_msg_buffer;
   import can_rx_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   can_rx_msg_buffer_if bus();

   logic [3:0][31:0] r_regs;
   logic             sw_we = 1'b0;
   logic [31:0]      sw_data = '0;

   assign bus.reg_data_i = r_regs;

   // Register interface: image load has priority, software writes blocked during new_data.
   always @(posedge clk) begin
      if (!rst_n)              r_regs <= '0;
      else if (bus.new_data_o) r_regs <= bus.reg_data_o;
      else if (sw_we)          r_regs[0] <= sw_data;
   end

   can_rx_msg_buffer #(.DEPTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int     n_checks = 0;
   int     n_fail   = 0;
   frame_t sb_q[$];

   function automatic logic [31:0] exp_w1(input frame_t f);
      return {12'b0, f.dlc, f.rtr, 4'b0, f.id};
   endfunction

   function automatic logic [95:0] exp_head();
      if (sb_q.size() == 0) return '0;
      return {sb_q[0].data, exp_w1(sb_q[0])};
   endfunction

   function automatic logic [31:0] exp_w0(input int cnt, input bit ovf, input int drop);
      return {8'(drop), 8'(cnt), 6'b0, ovf, (cnt != 0), 8'b0};
   endfunction

   function automatic frame_t rand_frame();
      frame_t f;
      f.id   = 11'($urandom);
      f.rtr  = 1'($urandom);
      f.dlc  = 4'($urandom);
      f.data = {$urandom, $urandom};
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_frame(input frame_t f, input bit accept);
      bus.frm_id_i    = f.id;
      bus.frm_rtr_i   = f.rtr;
      bus.frm_dlc_i   = f.dlc;
      bus.frm_data_i  = f.data;
      bus.frm_valid_i = 1'b1;
      if (accept) sb_q.push_back(f);
      tick();
      bus.frm_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.frm_valid_i = 1'b0;
      sw_we = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      sb_q.delete();
   endtask

   task automatic sw_write(input logic [31:0] d);
      int n = 0;
      while (bus.new_data_o && n < 20) begin tick(); n++; end
      sw_data = d;
      sw_we   = 1'b1;
      tick();
      sw_we   = 1'b0;
   endtask

   task automatic wait_update(input string name);
      int n = 0;
      bit saw = 1'b0;
      while (!bus.new_data_o && n < 20) begin tick(); n++; end
      while (bus.new_data_o && n < 40) begin saw = 1'b1; tick(); n++; end
      n_checks++;
      if (!saw || bus.new_data_o)
         begin n_fail++; $display("FAIL %s_update: saw_pulse=%0b new_data=%0b required pulse then 0", name, saw, bus.new_data_o); end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (bus.new_data_o !== 1'b0) begin n_fail++; $display("FAIL reset_new_data: got %b want 0", bus.new_data_o); end
      n_checks++;
      if (bus.reg_data_o !== '0) begin n_fail++; $display("FAIL reset_image: got %h want 0", bus.reg_data_o); end
   endtask

   task automatic test_single_frame();
      frame_t f;
      do_reset();
      f = '{id: 11'h123, rtr: 1'b0, dlc: 4'd8, data: 64'h1122334455667788};
      drive_frame(f, 1'b1);
      n_checks++;
      if (bus.new_data_o !== 1'b1) begin n_fail++; $display("FAIL single_latency: new_data got %b want 1", bus.new_data_o); end
      tick();
      n_checks++;
      if (bus.new_data_o !== 1'b0) begin n_fail++; $display("FAIL single_pulse_len: new_data got %b want 0", bus.new_data_o); end
      n_checks++;
      if (r_regs !== {32'h11223344, 32'h55667788, 32'h00080123, 32'h00010100})
         begin n_fail++; $display("FAIL single_image: got %h want 11223344_55667788_00080123_00010100", r_regs); end
      n_checks++;
      if (r_regs[3:1] !== exp_head()) begin n_fail++; $display("FAIL single_head_sb: got %h want %h", r_regs[3:1], exp_head()); end
   endtask

   task automatic test_pop_sequence();
      do_reset();
      for (int i = 0; i < 3; i++) drive_frame(rand_frame(), 1'b1);
      wait_update("seq_fill");
      n_checks++;
      if (r_regs[0] !== 32'h0003_0100) begin n_fail++; $display("FAIL seq_fill_w0: got %h want 00030100", r_regs[0]); end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (r_regs[3:1] !== exp_head()) begin n_fail++; $display("FAIL seq_head%0d: got %h want %h", i, r_regs[3:1], exp_head()); end
         sw_write(32'h1);
         wait_update("seq_pop");
         void'(sb_q.pop_front());
         n_checks++;
         if (r_regs[0] !== exp_w0(sb_q.size(), 1'b0, 0))
            begin n_fail++; $display("FAIL seq_w0_%0d: got %h want %h", i, r_regs[0], exp_w0(sb_q.size(), 1'b0, 0)); end
      end
      n_checks++;
      if (r_regs !== '0) begin n_fail++; $display("FAIL seq_final: got %h want 0", r_regs); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 10; i++) drive_frame(rand_frame(), i < 8);
      wait_update("ovf_fill");
      n_checks++;
      if (r_regs[0] !== 32'h0208_0300) begin n_fail++; $display("FAIL ovf_w0: got %h want 02080300", r_regs[0]); end
      n_checks++;
      if (r_regs[3:1] !== exp_head()) begin n_fail++; $display("FAIL ovf_head: got %h want %h", r_regs[3:1], exp_head()); end
      sw_write(32'h2);
      wait_update("ovf_clr");
      n_checks++;
      if (r_regs[0] !== 32'h0208_0100) begin n_fail++; $display("FAIL ovf_clr_w0: got %h want 02080100", r_regs[0]); end
   endtask

   // Continues from the full FIFO left by test_overflow.
   task automatic test_full_push_pop();
      frame_t nf;
      nf = rand_frame();
      sw_write(32'h1);
      void'(sb_q.pop_front());
      drive_frame(nf, 1'b1);
      wait_update("fpp");
      n_checks++;
      if (r_regs[0] !== 32'h0208_0100) begin n_fail++; $display("FAIL fpp_w0: got %h want 02080100", r_regs[0]); end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (r_regs[3:1] !== exp_head()) begin n_fail++; $display("FAIL fpp_head%0d: got %h want %h", i, r_regs[3:1], exp_head()); end
         if (i == 7) begin
            n_checks++;
            if (r_regs[1] !== exp_w1(nf)) begin n_fail++; $display("FAIL fpp_last: got %h want %h", r_regs[1], exp_w1(nf)); end
         end
         sw_write(32'h1);
         wait_update("fpp_pop");
         void'(sb_q.pop_front());
      end
      n_checks++;
      if (r_regs !== {96'b0, 32'h0200_0000}) begin n_fail++; $display("FAIL fpp_drained: got %h want 0..02000000", r_regs); end
   endtask

   task automatic test_pop_empty();
      int pulses = 0;
      do_reset();
      sw_write(32'h1);
      n_checks++;
      if (bus.new_data_o !== 1'b0 || r_regs[0] !== 32'h1)
         begin n_fail++; $display("FAIL pe_detect: new_data=%b w0=%h want 0 / 00000001", bus.new_data_o, r_regs[0]); end
      tick();
      n_checks++;
      if (bus.new_data_o !== 1'b1) begin n_fail++; $display("FAIL pe_pulse: new_data got %b want 1", bus.new_data_o); end
      tick();
      n_checks++;
      if (r_regs !== '0) begin n_fail++; $display("FAIL pe_image: got %h want 0", r_regs); end
      for (int i = 0; i < 4; i++) begin
         if (bus.new_data_o) pulses++;
         tick();
      end
      n_checks++;
      if (pulses != 0) begin n_fail++; $display("FAIL pe_extra_pulses: got %0d want 0", pulses); end
   endtask

   task automatic test_reset_mid_update();
      frame_t f;
      do_reset();
      drive_frame(rand_frame(), 1'b0);
      drive_frame(rand_frame(), 1'b0);
      n_checks++;
      if (bus.new_data_o !== 1'b1) begin n_fail++; $display("FAIL rmu_in_update: new_data got %b want 1", bus.new_data_o); end
      f = rand_frame();
      bus.frm_id_i = f.id; bus.frm_rtr_i = f.rtr; bus.frm_dlc_i = f.dlc; bus.frm_data_i = f.data;
      bus.frm_valid_i = 1'b1;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.frm_valid_i = 1'b0;
      n_checks++;
      if (bus.new_data_o !== 1'b0 || bus.reg_data_o !== '0 || r_regs !== '0)
         begin n_fail++; $display("FAIL rmu_after_reset: new_data=%b image=%h regs=%h want all 0", bus.new_data_o, bus.reg_data_o, r_regs); end
      drive_frame(rand_frame(), 1'b1);
      n_checks++;
      if (bus.new_data_o !== 1'b1) begin n_fail++; $display("FAIL rmu_next_pulse: new_data got %b want 1", bus.new_data_o); end
      tick();
      n_checks++;
      if (r_regs[0] !== 32'h0001_0100 || r_regs[3:1] !== exp_head())
         begin n_fail++; $display("FAIL rmu_clean: got %h want %h_00010100", r_regs, exp_head()); end
   endtask

   initial begin
      bus.frm_valid_i = 1'b0;
      bus.frm_id_i    = '0;
      bus.frm_rtr_i   = 1'b0;
      bus.frm_dlc_i   = '0;
      bus.frm_data_i  = '0;
      test_reset();
      test_single_frame();
      test_pop_sequence();
      test_overflow();
      test_full_push_pop();
      test_pop_empty();
      test_reset_mid_update();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "timeout");
   end
endmodule
